// File: rtl/in_fm_tile_loader.sv
// Input-feature-map tile loader: walks one Tn x TRI x TCI tile in raster order,
// reads in-bounds words from in_fm memory and zero-fills out-of-map positions into the FIFO.
module in_fm_tile_loader #(
    parameter int N      = 128,
    parameter int R      = 128,
    parameter int C      = 128,
    parameter int Tn     = 16,
    parameter int Tr     = 64,
    parameter int Tc     = 16,
    parameter int K      = 3,
    parameter int S      = 1,
    parameter int RD_LAT = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] n0,
    input  logic [AW-1:0] r0,
    input  logic [AW-1:0] c0,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    input  logic          fifo_almost_full,
    output logic          fifo_push,
    output logic [DW-1:0] fifo_data,
    output logic          busy,
    output logic          done
);
    localparam int TRI = (Tr - 1) * S + K;
    localparam int TCI = (Tc - 1) * S + K;

    localparam logic [AW-1:0] TN_M1  = AW'(Tn - 1);
    localparam logic [AW-1:0] TRI_M1 = AW'(TRI - 1);
    localparam logic [AW-1:0] TCI_M1 = AW'(TCI - 1);
    localparam logic [AW-1:0] N_A    = AW'(N);
    localparam logic [AW-1:0] R_A    = AW'(R);
    localparam logic [AW-1:0] C_A    = AW'(C);
    localparam logic [AW-1:0] RC_A   = AW'(R * C);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] n0_q, n0_d, r0_q, r0_d, c0_q, c0_d;
    logic [AW-1:0] n_q, n_d, r_q, r_d, c_q, c_d;
    logic [AW-1:0] addr_q, addr_d;

    // Valid and pad travel together so zero-fill words keep the memory latency.
    logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d, vld_shift;
    logic [RD_LAT-1:0] pad_pipe_q, pad_pipe_d;

    logic          issue, is_pad, c_last, r_last, n_last;
    logic [AW-1:0] elem_addr;

    assign c_last    = (c_q == c0_q + TCI_M1);
    assign r_last    = (r_q == r0_q + TRI_M1);
    assign n_last    = (n_q == n0_q + TN_M1);
    assign is_pad    = (n_q >= N_A) || (r_q >= R_A) || (c_q >= C_A);
    assign elem_addr = n_q * RC_A + r_q * C_A + c_q;
    assign issue     = (state_q == S_ISSUE) && !fifo_almost_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n0_q       <= '0;
            r0_q       <= '0;
            c0_q       <= '0;
            n_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            addr_q     <= '0;
            vld_pipe_q <= '0;
            pad_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            n0_q       <= n0_d;
            r0_q       <= r0_d;
            c0_q       <= c0_d;
            n_q        <= n_d;
            r_q        <= r_d;
            c_q        <= c_d;
            addr_q     <= addr_d;
            vld_pipe_q <= vld_pipe_d;
            pad_pipe_q <= pad_pipe_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        n0_d          = n0_q;
        r0_d          = r0_q;
        c0_d          = c0_q;
        n_d           = n_q;
        r_d           = r_q;
        c_d           = c_q;
        addr_d        = addr_q;
        vld_shift     = vld_pipe_q << 1;
        vld_pipe_d    = vld_shift;
        vld_pipe_d[0] = issue;
        pad_pipe_d    = pad_pipe_q << 1;
        pad_pipe_d[0] = issue && is_pad;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n0_d    = n0;
                    r0_d    = r0;
                    c0_d    = c0;
                    n_d     = n0;
                    r_d     = r0;
                    c_d     = c0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    if (!is_pad) addr_d = elem_addr;
                    if (c_last) begin
                        c_d = c0_q;
                        if (r_last) begin
                            r_d = r0_q;
                            n_d = n_q + AW'(1);
                        end else begin
                            r_d = r_q + AW'(1);
                        end
                    end else begin
                        c_d = c_q + AW'(1);
                    end
                    if (c_last && r_last && n_last) state_d = S_DRAIN;
                end
            end
            // Leave once only the tail word remains, so done lands right after the last push.
            S_DRAIN: begin
                if (vld_shift == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pads do not disturb the address bus; it keeps the last real read.
    assign mem_rd_addr = (issue && !is_pad) ? elem_addr : addr_q;
    assign fifo_push   = vld_pipe_q[RD_LAT-1];
    assign fifo_data   = (fifo_push && !pad_pipe_q[RD_LAT-1]) ? mem_rd_data : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_in_fm_tile_loader.sv
// Self-checking bench for in_fm_tile_loader: table of directed tiles, random origins
// with random backpressure, and reset-abort, all against a raster-order tile model.
module tb_in_fm_tile_loader;
    localparam int N = 4, R = 5, C = 5, TN = 2, TR = 2, TC = 2, K = 3, S = 1;
    localparam int RD_LAT = 2, AW = 32, DW = 32;
    localparam int TRI = (TR - 1) * S + K;
    localparam int TCI = (TC - 1) * S + K;
    localparam int TW  = TN * TRI * TCI;

    logic          clk = 1'b0;
    logic          rst, start, af;
    logic [AW-1:0] n0, r0, c0, mem_rd_addr;
    logic [DW-1:0] mem_rd_data, fifo_data;
    logic          fifo_push, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    in_fm_tile_loader #(
        .N(N), .R(R), .C(C), .Tn(TN), .Tr(TR), .Tc(TC), .K(K), .S(S),
        .RD_LAT(RD_LAT), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n0(n0), .r0(r0), .c0(c0),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .fifo_almost_full(af), .fifo_push(fifo_push), .fifo_data(fifo_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // in_fm memory: mem[a] = a + 100, two-cycle read latency
    logic [AW-1:0] a1, a2;
    always @(posedge clk) begin
        a1 <= mem_rd_addr;
        a2 <= a1;
    end
    assign mem_rd_data = (a2 < 32'd100) ? a2 + 32'd100 : 32'hDEADBEEF;

    bit mon_en = 1'b0;
    int got_q[$];
    int got_c[$];
    int done_c[$];
    always @(negedge clk) begin
        if (mon_en) begin
            if (fifo_push) begin
                got_q.push_back(int'(fifo_data));
                got_c.push_back(cyc);
            end
            if (done) done_c.push_back(cyc);
        end
    end

    bit af_pat[256];
    int exp_q[$];
    int iss_off[$];
    int exp_done_off;
    int last_addr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Tile contents in raster order plus issue timing implied by the almost_full pattern.
    task automatic build_model(input int n, input int r, input int c);
        int issued, k;
        exp_q.delete();
        iss_off.delete();
        for (int i = 0; i < TN; i++)
            for (int j = 0; j < TRI; j++)
                for (int m = 0; m < TCI; m++) begin
                    if (n + i >= N || r + j >= R || c + m >= C) exp_q.push_back(0);
                    else begin
                        last_addr = (n + i) * R * C + (r + j) * C + (c + m);
                        exp_q.push_back(last_addr + 100);
                    end
                end
        issued = 0;
        k = 1;
        while (issued < TW) begin
            if (!af_pat[k]) begin
                iss_off.push_back(k);
                issued++;
            end
            k++;
        end
        exp_done_off = iss_off[TW-1] + RD_LAT + 1;
    endtask

    task automatic run_tile(input string nm, input int n, input int r, input int c,
                            input int illegal_at, input int exp_p0, input int exp_p5,
                            input int exp_done);
        int t0, budget, cnt;
        build_model(n, r, c);
        got_q.delete();
        got_c.delete();
        done_c.delete();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b1;
        n0 = n;
        r0 = r;
        c0 = c;
        af = af_pat[0];
        budget = 0;
        while (done_c.size() == 0 && budget < 250) begin
            @(posedge clk);
            #1;
            budget++;
            start = (budget == illegal_at);
            if (start) begin
                n0 = 1;
                r0 = 3;
                c0 = 3;
            end
            af = af_pat[budget];
        end
        start = 1'b0;
        af = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk({nm, " push count"}, got_q.size(), TW);
        cnt = (got_q.size() < TW) ? got_q.size() : TW;
        for (int i = 0; i < cnt; i++) begin
            chk($sformatf("%s data[%0d]", nm, i), got_q[i], exp_q[i]);
            chk($sformatf("%s push cycle[%0d]", nm, i), got_c[i] - t0, iss_off[i] + RD_LAT);
        end
        if (cnt > 5 && exp_p0 >= 0) begin
            chk({nm, " push0"}, got_q[0], exp_p0);
            chk({nm, " push5"}, got_q[5], exp_p5);
        end
        chk({nm, " done pulses"}, done_c.size(), 1);
        if (done_c.size() > 0) begin
            chk({nm, " done cycle"}, done_c[0] - t0, exp_done_off);
            if (exp_done >= 0) chk({nm, " done abs"}, done_c[0] - t0, exp_done);
        end
        chk({nm, " busy after"}, busy, 0);
        chk({nm, " addr held"}, mem_rd_addr, last_addr);
    endtask

    typedef struct {
        string nm;
        int    n, r, c;
        int    af_s, af_l;
        int    illegal_at;
        int    exp_p0, exp_p5, exp_done;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cnt;
        tbl[0] = '{"interior",      0, 0, 0, 0, 0, -1, 100, 106, 35};
        tbl[1] = '{"edge pad",      0, 2, 2, 0, 0, -1, 112, 118, 35};
        tbl[2] = '{"chan overrun",  3, 0, 0, 0, 0, -1, 175, 181, 35};
        tbl[3] = '{"backpressure",  0, 0, 0, 4, 5, -1, 100, 106, 40};
        tbl[4] = '{"start midload", 0, 0, 0, 0, 0, 10, 100, 106, 35};
        tbl[5] = '{"start on done", 0, 0, 0, 0, 0, 35, 100, 106, 35};

        rst = 1'b1;
        start = 1'b0;
        af = 1'b0;
        n0 = '0;
        r0 = '0;
        c0 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset addr", mem_rd_addr, 0);
        chk("reset push", fifo_push, 0);
        chk("reset data", fifo_data, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            for (int k = 0; k < 256; k++)
                af_pat[k] = (k >= tbl[i].af_s) && (k < tbl[i].af_s + tbl[i].af_l);
            run_tile(tbl[i].nm, tbl[i].n, tbl[i].r, tbl[i].c, tbl[i].illegal_at,
                     tbl[i].exp_p0, tbl[i].exp_p5, tbl[i].exp_done);
        end

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 256; k++) af_pat[k] = ($urandom_range(0, 3) == 0);
            run_tile($sformatf("rand%0d", it), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), -1, -1, -1, -1);
        end

        // Reset abort in the middle of a load, then a fresh tile.
        for (int k = 0; k < 256; k++) af_pat[k] = 1'b0;
        got_q.delete();
        got_c.delete();
        done_c.delete();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        n0 = 0;
        r0 = 0;
        c0 = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort busy before", busy, 1);
        chk("abort push before", fifo_push, 1);
        rst = 1'b1;
        #1;
        chk("abort push", fifo_push, 0);
        chk("abort data", fifo_data, 0);
        chk("abort addr", mem_rd_addr, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        cnt = got_q.size();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort no pushes", got_q.size(), cnt);
        chk("abort no done", done_c.size(), 0);
        mon_en = 1'b0;
        last_addr = 0;
        run_tile("fresh", 0, 0, 0, -1, 100, 106, 35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/in_fm_tile_loader.md
# in_fm_tile_loader

Upstream fill stage for the conv tile datapath. It reads one input-feature-map tile (Tn channels × TRI rows × TCI columns) from external in_fm memory, which has a fixed read latency. It pushes the words, in raster order, into the FIFO that the fifo→RAM transfer stage drains into the on-chip tile buffer. Positions outside the N×R×C feature map are zero-filled, so the tile buffer always receives exactly Tn·TRI·TCI words.

## Interface
- N, 128: total input channels
- R, 128: input rows
- C, 128: input columns
- Tn, 16: channels per tile
- Tr, 64: output rows per tile
- Tc, 16: output columns per tile
- K, 3: kernel size
- S, 1: stride
- RD_LAT, 2: external memory read latency in cycles (address to data)
- AW, 32: address width
- DW, 32: data width
- Derived: TRI=(Tr-1)·S+K; TCI=(Tc-1)·S+K; TILE_WORDS=Tn·TRI·TCI

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; samples tile origin
- n0  in  AW  first channel of tile
- r0  in  AW  first input row of tile
- c0  in  AW  first input column of tile
- mem_rd_addr  out  AW  in_fm address; data returns RD_LAT cycles later
- mem_rd_data  in  DW  in_fm read data
- fifo_almost_full  in  1  FIFO has ≤ RD_LAT+1 free slots
- fifo_push  out  1  write fifo_data this cycle
- fifo_data  out  DW  word to FIFO
- busy  out  1  tile load in progress
- done  out  1  one-cycle pulse; all TILE_WORDS pushed

## Operation
- Address map: addr = n·R·C + r·C + c, computed with AW-bit arithmetic; no base offset.
- Order: c fastest (c0..c0+TCI-1), then r (r0..r0+TRI-1), then n (n0..n0+Tn-1).
- State machine:
  - IDLE: waits for start; latches n0/r0/c0; clears counters; goes to ISSUE.
  - ISSUE: each cycle with fifo_almost_full=0, issues one element.
    - An element is a pad if n≥N, r≥R or c≥C; otherwise it is a real read.
    - mem_rd_addr is driven for real reads. For pads it holds the previous value.
    - The element enters the RD_LAT-deep valid/pad shift pipeline.
    - After the last element is issued, the FSM goes to DRAIN.
  - DRAIN: waits until the pipeline is empty, then goes to DONE.
  - DONE: pulses done for one cycle, then returns to IDLE.
- Pipeline output stage:
  - fifo_push equals the valid bit at the pipeline tail.
  - fifo_data is 0 for a pad element and mem_rd_data otherwise.
  - Pads keep the same latency as real reads, so FIFO order always matches issue order.
- Backpressure:
  - fifo_almost_full only stalls issue. In-flight pipeline words always push.
  - The FIFO headroom requirement (≥RD_LAT+1 free slots when almost_full asserts) guarantees no overflow.
- start while busy=1 is ignored.
- busy=1 in ISSUE, DRAIN and DONE.

## Timing
- Reset values: mem_rd_addr=0, fifo_push=0, fifo_data=0, busy=0, done=0; FSM in IDLE, pipeline cleared.
- Assertion of rst mid-load aborts immediately. No further pushes occur and done is not pulsed.
- Pipeline without stalls:
  - start sampled at edge t.
  - First address at cycle t+1.
  - First fifo_push at cycle t+1+RD_LAT.
  - Throughput of 1 word/cycle.
  - Last push at t+RD_LAT+TILE_WORDS.
  - done at t+RD_LAT+TILE_WORDS+1, the cycle after the last push.
- Stall: when fifo_almost_full=1 at a cycle, no element is issued that cycle. Each stall cycle delays done by exactly one cycle.
- Counter wrap:
  - c wraps to c0 and r increments in the same cycle.
  - At r wrap, n increments.
  - The terminal element is (n0+Tn-1, r0+TRI-1, c0+TCI-1).
- A start in the same cycle as done is ignored. start is only accepted in IDLE.

## Test plan
Bench parameters: N=4, R=5, C=5, Tn=2, Tr=2, Tc=2, K=3, S=1, RD_LAT=2, giving TRI=TCI=4 and TILE_WORDS=32. Memory init mem[a]=a+100.

1. Interior tile, no stall:
   - Stimulus: origin (0,0,0), start at t.
   - Required: 32 pushes on cycles t+3..t+34. Push 0 carries 100, push 5 (r=1, c=1) carries 106. done at t+35.
2. Edge padding:
   - Stimulus: origin (0,2,2).
   - Required: rows 2..5 and cols 2..5. Every element with r=5 or c=5 is pushed as 0. Push 0 carries 112 (addr 12). 32 pushes total.
3. Channel overrun:
   - Stimulus: origin (3,0,0).
   - Required: pushes 0..15 carry mem[75+…]. Pushes 16..31 are all 0 with no new mem_rd_addr values.
4. Backpressure:
   - Stimulus: origin (0,0,0); hold fifo_almost_full=1 for 5 cycles starting at t+4.
   - Required: issue pauses but ≤RD_LAT in-flight words still push. Data order is identical to scenario 1. done at t+40.
5. Illegal start and reset abort:
   - Stimulus: pulse start again mid-load.
   - Required: ignored; the output stream is unchanged.
   - Stimulus: assert rst mid-load.
   - Required: all outputs return to 0 at once. A following start produces a fresh, complete 32-word tile.
